async_fifo: RTL and testbench
=============================

# async_fifo

Single-clock, first-in-first-out buffer using Gray-coded pointers, with a `WIDTH`-bit data path and `DEPTH` entries. It sits between a producer and a consumer stage in the sample datapath and decouples their burst behaviour. The pointer logic is structured so that the pointer synchronizers can be enabled for later dual-clock use without changing the interface.

## Interface
- `WIDTH`, 32, data word width in bits; must be ≥ 1.
- `DEPTH`, 16, number of entries; must be a power of two and ≥ 4.
- `clk`  in  1  single clock; all logic is rising-edge triggered.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk`.
- `din`  in  `WIDTH`  write data, sampled on the edge where `wr_en` is high.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read request.
- `dout`  out  `WIDTH`  registered read data.
- `full`  out  1  registered; high means a write is not accepted.
- `empty`  out  1  registered; high means a read is not accepted.

## Operation
- Storage: `DEPTH` × `WIDTH` array. Pointers are `AW+1` bits wide, where `AW = $clog2(DEPTH)`. Each pointer is kept in both binary and Gray form.
- A write is accepted when `wr_en && !full`:
  - `mem[wptr[AW-1:0]] <= din`.
  - The write pointer increments.
- A read is accepted when `rd_en && !empty`:
  - `dout <= mem[rptr[AW-1:0]]`.
  - The read pointer increments.
- If `full` is high, writes are ignored: no pointer change, no memory change.
- If `empty` is high, reads are ignored: `dout` holds its value.
- A simultaneous accepted read and write are both performed. The occupancy is unchanged.
- Wrap-around: pointers roll over modulo `2·DEPTH`. The extra MSB distinguishes a full FIFO from an empty one.
- Flag rules:
  - Empty: the Gray read pointer equals the (synchronized) Gray write pointer.
  - Full: the Gray write pointer equals the (synchronized) Gray read pointer with its two MSBs inverted.
- Reset (asynchronous, at any time, including mid-operation):
  - Pointers and synchronizer flops clear.
  - `empty=1`, `full=0`, `dout=0`.
  - Memory contents are not cleared and are not observable.

## Timing
- Read latency is 1 cycle. When `rd_en` is sampled high at edge N with `!empty`, the word is on `dout` just after edge N and holds until the next accepted read.
- Flags are computed from the post-increment pointer values and registered.
- With `ASYNC_FIFO_SYNC_EN` undefined:
  - A write at edge N clears `empty` after edge N.
  - The write that fills the last entry sets `full` after the same edge.
- With `ASYNC_FIFO_SYNC_EN` defined, flag updates caused by the opposite side lag by 2 cycles: a write at edge N clears `empty` after edge N+2. The flags are conservative:
  - `empty` may stay high spuriously; it never goes low early.
  - `full` may stay high spuriously; it never goes low early.
- Own-side flag assertion is immediate in both modes: `empty` after the last read, `full` after the last write.
- No overflow or underflow can occur in either mode.

## Configuration
- Macro: `ASYNC_FIFO_SYNC_EN`.
- Defined: each Gray pointer passes through a 2-flop synchronizer before the opposite-side comparison. This is the structure required for dual-clock migration.
- Undefined: pointers are compared directly, with zero extra latency.
- Ports and data behaviour are identical in both modes; only flag latency differs.

## Structure
- Package `async_fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions.
  - The address-width helper `$clog2`-based constant function.
  - Default `WIDTH`/`DEPTH` localparams.
- Sub-module `fifo_sync2`: parameterized-width 2-flop synchronizer with async active-low reset to 0. It is instantiated twice, only under `ASYNC_FIFO_SYNC_EN`.

## Test plan
- Reset held for 100 ns, then released -> `empty=1`, `full=0`, `dout=0`.
- Write 0..7, one word every other cycle; wait 200 ns; read 8 single-cycle pulses -> `dout` is 0,1,…,7 in order, 1 ns after each read edge; then `empty=1`.
- Write 16 words (`DEPTH`=16) -> `full=1`. A 17th write of 0xDEADBEEF is ignored. Read all 16 back -> the original 16 values in order, with no 0xDEADBEEF.
- Read with `empty=1` -> `dout` unchanged and the pointers are not advanced. A subsequent write of 0x5 followed by a read returns 0x5.
- With the FIFO half full, hold `wr_en` and `rd_en` high together for 40 cycles -> occupancy stays constant and the data order is preserved across pointer wrap-around.
- Assert `rst_n` low mid-burst -> `empty=1`, `full=0`, `dout=0` immediately. After release, a write of 0xA followed by a read returns 0xA.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg
//   Shared helpers for the Gray-pointer FIFO: default geometry, the
//   address-width helper and binary/Gray conversion functions.
//   The conversion functions operate on 32-bit values; callers cast to
//   their own pointer width (pointer widths never exceed 32 bits).
package async_fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;

  // Number of address bits needed to index 'depth' entries.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync2.sv
// fifo_sync2
//   Two-flop synchronizer for a multi-bit Gray-coded pointer.
//   Ports:
//     clk    - sampling clock
//     rst_n  - asynchronous active-low reset, clears both stages to 0
//     d_i    - value to synchronize
//     q_o    - value after two register stages
module fifo_sync2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/async_fifo.sv
// async_fifo
//   Single-clock FIFO with Gray-coded pointers, DEPTH x WIDTH storage.
//   Build option: define ASYNC_FIFO_SYNC_EN to route each Gray pointer
//   through a 2-flop synchronizer before the opposite-side flag compare
//   (dual-clock-ready structure, flags lag by 2 cycles but stay
//   conservative). Undefined: pointers are compared directly.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset
//     din    - write data, taken when wr_en && !full
//     wr_en  - write request
//     rd_en  - read request, taken when !empty
//     dout   - registered read data (1-cycle latency, holds otherwise)
//     full   - registered, writes ignored while high
//     empty  - registered, reads ignored while high
//   DEPTH must be a power of two and >= 4; WIDTH >= 1.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t wbin_q, wbin_d, wgray_q, wgray_d;
  ptr_t rbin_q, rbin_d, rgray_q, rgray_d;
  ptr_t wgray_s, rgray_s;

  logic             wr_acc, rd_acc;
  logic             full_q, full_d, empty_q, empty_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    wr_acc  = wr_en & ~full_q;
    rd_acc  = rd_en & ~empty_q;
    wbin_d  = wbin_q + PW'(wr_acc);
    rbin_d  = rbin_q + PW'(rd_acc);
    wgray_d = wr_acc ? ptr_t'(bin2gray(32'(wbin_d))) : wgray_q;
    rgray_d = rd_acc ? ptr_t'(bin2gray(32'(rbin_d))) : rgray_q;
    dout_d  = rd_acc ? mem[rbin_q[AW-1:0]] : dout_q;
    // Flags use post-increment pointers so own-side assertion is immediate.
    empty_d = (rgray_d == wgray_s);
    // Gray full test: top two bits inverted, remaining bits equal.
    full_d  = (wgray_d == {~rgray_s[PW-1:PW-2], rgray_s[PW-3:0]});
  end

`ifdef ASYNC_FIFO_SYNC_EN
  // Synchronizers sample the next-state Gray value, so the first stage
  // mirrors the source pointer register and the opposite-side flag sees
  // the update two edges later.
  fifo_sync2 #(.W(PW)) u_wsync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (wgray_d),
    .q_o   (wgray_s)
  );

  fifo_sync2 #(.W(PW)) u_rsync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rgray_d),
    .q_o   (rgray_s)
  );
`else
  assign wgray_s = wgray_d;
  assign rgray_s = rgray_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rbin_q  <= '0;
      rgray_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is never reset; its contents are unobservable until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wbin_q[AW-1:0]] <= din;
    end
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;

  localparam int W = 32;
  localparam int D = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din   = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  wire  [W-1:0] dout;
  wire          full;
  wire          empty;

  always #5 clk = ~clk;

  async_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  bit           chk_en = 1'b0;
  bit           m_wa, m_ra;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus the last word read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_dout = '0;
    end else begin
      m_wa = wr_en && (mq.size() < D);
      m_ra = rd_en && (mq.size() > 0);
      if (m_ra) begin
        m_dout = mq[0];
        void'(mq.pop_front());
      end
      if (m_wa) mq.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_empty", 32'(empty), 32'(mq.size() == 0));
      chk("model_full",  32'(full),  32'(mq.size() == D));
      chk("model_dout",  dout,       m_dout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] v);
    wr_en = 1'b1;
    din   = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset held for 100 ns
    #100;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dout",  dout,       32'd0);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;

    // Sparse writes, then ordered reads
    for (int i = 0; i < 8; i++) begin
      wr(32'(i));
      step();
    end
    chk("t2_not_empty", 32'(empty), 32'd0);
    repeat (20) step();
    for (int i = 0; i < 8; i++) begin
      rd();
      chk("t2_dout", dout, 32'(i));
      step();
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) wr(32'h100 + 32'(i));
    chk("t3_full", 32'(full), 32'd1);
    wr(32'hDEADBEEF);
    chk("t3_full_hold", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("t3_dout", dout, 32'h100 + 32'(i));
    end
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_not_full", 32'(full), 32'd0);

    // Underflow attempt
    rd();
    chk("t4_dout_hold", dout, 32'h10F);
    chk("t4_empty", 32'(empty), 32'd1);
    wr(32'h5);
    rd();
    chk("t4_dout", dout, 32'h5);

    // Half full, simultaneous read/write across wrap-around
    for (int i = 0; i < 8; i++) wr(32'h200 + 32'(i));
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 32'h300 + 32'(k);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("t5_last_dout", dout, 32'h31F);
    chk("t5_empty", 32'(empty), 32'd0);
    chk("t5_full",  32'(full),  32'd0);
    for (int i = 0; i < 8; i++) begin
      rd();
      chk("t5_drain", dout, 32'h320 + 32'(i));
    end
    chk("t5_end_empty", 32'(empty), 32'd1);

    // Reset in the middle of a burst
    for (int i = 0; i < 4; i++) wr(32'h40 + 32'(i));
    rd();
    rd();
    chk("t6_pre_dout", dout, 32'h41);
    wr_en = 1'b1;
    din   = 32'h44;
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dout",  dout,       32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_full",  32'(full),  32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    wr(32'hA);
    rd();
    chk("t6_dout", dout, 32'hA);
    chk("t6_empty", 32'(empty), 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
